// File: rtl/mcu51_pkg.sv
// Shared definitions for the 8051 core: op encodings, FSM states and PSW bit positions.
package mcu51_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PSW_CY = 7;
    localparam int PSW_AC = 6;
    localparam int PSW_OV = 2;
    localparam int PSW_P  = 0;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle MUL AB / DIV AB engine: one shared shift register and adder,
// one iteration per clock, results held until the next completion.
module mul_div_unit
    import mcu51_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic [7:0]       psw_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans_a,
    output logic [WIDTH-1:0] ans_b,
    output logic [7:0]       psw_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    function automatic logic [7:0] upd_psw(input logic [7:0] psw, input logic ov,
                                           input logic [WIDTH-1:0] res);
        logic [7:0] p;
        p         = psw;
        p[PSW_CY] = 1'b0;
        p[PSW_OV] = ov;
        p[PSW_P]  = ^res;
        return p;
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic                op_q;
    logic [7:0]          psw_q;
    logic [WIDTH-1:0]    opnd_q;
    logic [2*WIDTH-1:0]  sr_q, sr_nxt;
    logic [WIDTH:0]      x, y, sum;
    logic                cin;
    logic                accept, div0, last;

    assign accept = (state_q == IDLE) && start;
    assign div0   = (op == OP_DIV) && (b_data == '0);
    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = div0 ? DONE : RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                cnt_q <= '0;
            else if (state_q == RUN)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // DIV: trial-subtract via add of the complement; bit WIDTH of sum is the sign
    always_comb begin
        if (op_q == OP_DIV) begin
            x   = {sr_q[2*WIDTH-1:WIDTH], sr_q[WIDTH-1]};
            y   = ~{1'b0, opnd_q};
            cin = 1'b1;
        end else begin
            x   = {1'b0, sr_q[2*WIDTH-1:WIDTH]};
            y   = sr_q[0] ? {1'b0, opnd_q} : '0;
            cin = 1'b0;
        end
        sum = x + y + {{WIDTH{1'b0}}, cin};
        if (op_q == OP_DIV) begin
            if (!sum[WIDTH])
                sr_nxt = {sum[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b1};
            else
                sr_nxt = {x[WIDTH-1:0], sr_q[WIDTH-2:0], 1'b0};
        end else begin
            sr_nxt = {sum, sr_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op;
            psw_q <= psw_in;
            if (op == OP_DIV) begin
                sr_q   <= {{WIDTH{1'b0}}, a_data};
                opnd_q <= b_data;
            end else begin
                sr_q   <= {{WIDTH{1'b0}}, b_data};
                opnd_q <= a_data;
            end
        end else if (state_q == RUN) begin
            sr_q <= sr_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ans_a   <= '0;
            ans_b   <= '0;
            psw_out <= '0;
        end else if (accept && div0) begin
            ans_a   <= a_data;
            ans_b   <= '0;
            psw_out <= upd_psw(psw_in, 1'b1, a_data);
        end else if ((state_q == RUN) && last) begin
            ans_a   <= sr_nxt[WIDTH-1:0];
            ans_b   <= sr_nxt[2*WIDTH-1:WIDTH];
            psw_out <= upd_psw(psw_q,
                               (op_q == OP_MUL) && (sr_nxt[2*WIDTH-1:WIDTH] != '0),
                               sr_nxt[WIDTH-1:0]);
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus handshake, busy-start and reset sequences.
module tb_mul_div_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a_data = '0;
    logic [7:0] b_data = '0;
    logic [7:0] psw_in = '0;
    logic       busy, done;
    logic [7:0] ans_a, ans_b, psw_out;

    int checks = 0;
    int failures = 0;

    mul_div_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_data(a_data), .b_data(b_data), .psw_in(psw_in),
        .busy(busy), .done(done), .ans_a(ans_a), .ans_b(ans_b), .psw_out(psw_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic [7:0] a, b, psw;
        logic [7:0] ea, eb, epsw;
        int         lat;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drives one start at the next edge and returns the cycle in which done is seen (0 = never).
    task automatic launch(input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] p, output int lat);
        @(negedge clk);
        op = o; a_data = a; b_data = b; psw_in = p; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_data = 8'hA5; b_data = 8'h5A; psw_in = 8'hFF; op = ~o;
        lat = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        launch(v.op, v.a, v.b, v.psw, lat);
        check({name, "_latency"}, lat, v.lat);
        check({name, "_ans_a"}, ans_a, v.ea);
        check({name, "_ans_b"}, ans_b, v.eb);
        check({name, "_psw"}, psw_out, v.epsw);
        @(posedge clk);
        #1;
        check({name, "_idle_after"}, {busy, done}, 0);
        check({name, "_hold_a"}, ans_a, v.ea);
    endtask

    vec_t vecs[8];

    initial begin
        int lat;
        int ndone, d1, d2;
        logic [7:0] a1, a2;

        vecs[0] = '{1'b0, 8'h50, 8'hA0, 8'h80, 8'h00, 8'h32, 8'h04, 9};
        vecs[1] = '{1'b0, 8'h0C, 8'h0A, 8'h18, 8'h78, 8'h00, 8'h18, 9};
        vecs[2] = '{1'b1, 8'hFB, 8'h12, 8'h84, 8'h0D, 8'h11, 8'h01, 9};
        vecs[3] = '{1'b1, 8'h55, 8'h00, 8'h00, 8'h55, 8'h00, 8'h04, 1};
        vecs[4] = '{1'b0, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'h05, 9};
        vecs[5] = '{1'b1, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h7A, 9};
        vecs[6] = '{1'b1, 8'h07, 8'h09, 8'h41, 8'h00, 8'h07, 8'h40, 9};
        vecs[7] = '{1'b0, 8'h00, 8'h37, 8'h04, 8'h00, 8'h00, 8'h00, 9};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_outputs", {ans_a, ans_b, psw_out}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // start while busy is ignored; start in cycle 10 is accepted
        @(negedge clk);
        op = 1'b0; a_data = 8'h0C; b_data = 8'h0A; psw_in = 8'h18; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0; d1 = 0; d2 = 0; a1 = '0; a2 = '0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin d1 = cyc; a1 = ans_a; end
                if (ndone == 2) begin d2 = cyc; a2 = ans_a; end
            end
            if (cyc == 4) begin
                start = 1'b1; op = 1'b1; a_data = 8'h99; b_data = 8'h03;
            end else if (cyc == 10) begin
                start = 1'b1; op = 1'b0; a_data = 8'h03; b_data = 8'h04; psw_in = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("busy_start_done_count", ndone, 2);
        check("busy_start_first_done", d1, 9);
        check("busy_start_first_ans", a1, 8'h78);
        check("second_start_done", d2, 19);
        check("second_start_ans", a2, 8'h0C);

        // asynchronous reset in cycle 5 of a DIV
        @(negedge clk);
        op = 1'b1; a_data = 8'hFB; b_data = 8'h12; psw_in = 8'h84; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_outputs", {ans_a, ans_b, psw_out}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("rst_no_done", ndone, 0);
        launch(1'b0, 8'h03, 8'h04, 8'h00, lat);
        check("post_rst_latency", lat, 9);
        check("post_rst_ans_a", ans_a, 8'h0C);
        check("post_rst_ans_b", ans_b, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
